// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: digit count,
// hex-to-segment table (active-low {g,f,e,d,c,b,a}) and the blank pattern.
package seg_pkg;

  localparam int DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_display_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed hex display with frame-aligned value handshake.
// Define SEG_LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] val_data,
  input  logic        val_valid,
  output logic        val_ready,
  output logic [6:0]  seg,
  output logic [7:0]  ans
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  logic [CNT_W-1:0] divcnt_q, divcnt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       ans_q, ans_d;

  logic             tick;
  logic             blank;
  logic [3:0]       nibble;
  logic [6:0]       nibble_seg;

  hex7seg u_hex7seg (
    .hex (nibble),
    .seg (nibble_seg)
  );

  // Outputs are computed from the next-state digit and shadow so a value
  // captured on the frame-boundary tick already drives digit 0.
  always_comb begin
    tick      = (divcnt_q == DIV_LAST);
    val_ready = tick && (dig_q == DIG_LAST);
    divcnt_d  = tick ? '0 : divcnt_q + CNT_W'(1);
    dig_d     = tick ? dig_q + DIG_W'(1) : dig_q;
    shadow_d  = (val_valid && val_ready) ? val_data : shadow_q;
    nibble    = shadow_d[{dig_d, 2'b00} +: 4];
  end

`ifdef SEG_LEAD_ZERO_BLANK_EN
  always_comb begin
    blank = (dig_d != '0) && ((shadow_d >> {dig_d, 2'b00}) == 32'h0);
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_comb begin
    ans_d = ans_q;
    seg_d = seg_q;
    if (tick) begin
      if (blank) begin
        ans_d = 8'hFF;
        seg_d = SEG_BLANK;
      end else begin
        ans_d = ~(8'b1 << dig_d);
        seg_d = nibble_seg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divcnt_q <= '0;
      dig_q    <= '0;
      shadow_q <= 32'h0;
      ans_q    <= 8'hFE;
      seg_q    <= SEG_TABLE[0];
    end else begin
      divcnt_q <= divcnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      ans_q    <= ans_d;
      seg_q    <= seg_d;
    end
  end

  assign seg = seg_q;
  assign ans = ans_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display against a cycle-count reference model.
module tb_seg_scan_display;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = SCAN_DIV * 8;

  localparam logic [6:0] HEX_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] val_data = 32'h0;
  logic        val_valid = 1'b0;
  logic        val_ready;
  logic [6:0]  seg;
  logic [7:0]  ans;

  int          total = 0;
  int          bad = 0;
  int          e = 0;
  logic [31:0] shadow_m = 32'h0;

  seg_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .val_data  (val_data),
    .val_valid (val_valid),
    .val_ready (val_ready),
    .seg       (seg),
    .ans       (ans)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  // Expected display after e rising edges since reset release.
  task automatic check_display();
    int          d;
    logic [7:0]  a;
    logic [6:0]  s;
    logic [31:0] upper;
    d     = (e / SCAN_DIV) % 8;
    upper = shadow_m >> (4 * d);
    a     = ~(8'b1 << d);
    s     = HEX_REF[upper[3:0]];
`ifdef SEG_LEAD_ZERO_BLANK_EN
    if (d > 0 && upper == 32'h0) begin
      a = 8'hFF;
      s = 7'h7F;
    end
`endif
    check("ans", ans, a);
    check("seg", seg, s);
    check("ready", val_ready, (e % FRAME) == FRAME - 1);
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    val_valid = v;
    val_data  = d;
    @(posedge clk);
    if (v && (e % FRAME) == FRAME - 1) shadow_m = d;
    e++;
    @(negedge clk);
    check_display();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ans", ans, 8'hFE);
    check("rst_seg", seg, 7'h40);
    check("rst_ready", val_ready, 1'b0);
    reset = 1'b1;
    e = 0;
    shadow_m = 32'h0;

    repeat (40) step(1'b0, $urandom);
    repeat (2 * FRAME) step(1'b1, 32'h1234ABCD);
    for (int i = 0; i < 3 * FRAME; i++) step($urandom_range(0, 3) == 0, $urandom);
    repeat (2 * FRAME) step(1'b1, 32'h000000A5);
    repeat (2 * FRAME) step(1'b1, 32'h0);
    for (int i = 0; i < 3 * FRAME; i++) step(1'b1, $urandom);

    repeat (2 * FRAME) step(1'b1, 32'hFFFFFFFF);
    for (int i = 0; i < FRAME && ((e / SCAN_DIV) % 8) != 5; i++) step(1'b0, 32'h0);
    check("dig5_reached", (e / SCAN_DIV) % 8, 5);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ans", ans, 8'hFE);
    check("mid_rst_seg", seg, 7'h40);
    check("mid_rst_ready", val_ready, 1'b0);
    shadow_m  = 32'h0;
    e         = 0;
    val_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_display();
    repeat (FRAME + 8) step(1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
